// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master side is the execute stage and the slave side is the divider.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Returns {remainder, quotient} with ready_o held until start_i drops.
//
//   state    | meaning
//   S_FREE   | idle, waiting for an un-annulled request
//   S_BYZERO | divisor was zero, answer is all-zero
//   S_ON     | iterating (cnt 0..31), finalising signs at cnt == 32
//   S_END    | result valid, held until start_i is released
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs1, abs2;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot, rem;

    always_comb begin
        abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
        // The upper 33 bits hold the partial remainder; bit 32 of diff flags a borrow.
        shifted = work_q << 1;
        diff    = shifted[64:32] - {1'b0, divisor_q};
        quot    = q_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem     = r_neg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = 6'd0;
                        work_d    = {33'd0, abs1};
                        divisor_d = abs2;
                        q_neg_d   = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        r_neg_d   = bus.signed_div_i && bus.opdata1_i[31];
                    end
                end
            end
            S_BYZERO: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                    cnt_d   = 6'd0;
                end else begin
                    state_d  = S_END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else if (cnt_q < 6'd32) begin
                    if (!diff[32]) begin
                        work_d = {diff, shifted[31:0] | 32'd1};
                    end else begin
                        work_d = shifted;
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = S_END;
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = 6'd0;
                result_d = 64'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
